reaction_display: RTL and testbench

Consumer side of the reaction-timer result interface: samples the 16-bit elapsed-time count and the status strobes produced by the timer manager and drives a 4-digit multiplexed seven-segment display. On each rising edge of `show`, it latches the count, saturates it to 9999 and converts it to BCD with an iterative shift-add-3 engine (one bit per cycle). It then scans the digits continuously. While the timer is waiting to start, it shows dashes; otherwise the display is blank.

---
 rtl/reaction_pkg.sv | 24 ++
 rtl/seg7_encoder.sv | 26 ++
 rtl/reaction_display.sv | 145 ++++++++++++++
 tb/tb_reaction_display.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer result display.
package reaction_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHOW    = 2'd2
  } state_t;

  localparam int          NUM_DIGITS  = 4;
  localparam logic [15:0] MAX_DISPLAY = 16'd9999;
  localparam logic [6:0]  SEG_BLANK   = 7'h7F;
  localparam logic [6:0]  SEG_DASH    = 7'b0111111;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// BCD digit to active-low {g,f,e,d,c,b,a}; codes 10-15 are blank.
module seg7_encoder
  import reaction_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/reaction_display.sv
// Captures the timer result on a rising show edge, converts it to BCD one bit per cycle and
// scans it onto a 4-digit display. LEADING_ZERO_BLANK_EN blanks leading zeros of digits 3..1.
module reaction_display
  import reaction_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        show,
  input  logic        waiting,
  input  logic [15:0] value,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy,
  output logic        overflow
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_t             state_q, state_d;
  logic               show_q, show_d;
  logic [15:0]        bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [3:0]         iter_q, iter_d;
  logic [15:0]        digits_q, digits_d;
  logic               overflow_q, overflow_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         an_q, an_d;

  logic               start;
  logic               lz_blank;
  logic [3:0]         cur_digit;
  logic [6:0]         enc_seg;

  assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

  seg7_encoder u_enc (
    .bcd (cur_digit),
    .seg (enc_seg)
  );

  always_comb begin
    state_d    = state_q;
    show_d     = show;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    div_cnt_d  = div_cnt_q;
    idx_d      = idx_q;
    start      = show & ~show_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d      = (value > MAX_DISPLAY) ? MAX_DISPLAY : value;
          overflow_d = (value > MAX_DISPLAY);
          bcd_d      = '0;
          iter_d     = '0;
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {bcd_d, bin_d} = {bcd_adjust(bcd_q), bin_q} << 1;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          digits_d = bcd_d;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!show) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

`ifdef LEADING_ZERO_BLANK_EN
    case (idx_q)
      2'd3:    lz_blank = (digits_q[15:12] == 4'd0);
      2'd2:    lz_blank = (digits_q[15:8]  == 8'd0);
      2'd1:    lz_blank = (digits_q[15:4]  == 12'd0);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif

    // Outputs are built from the current idx so seg/dp/an change on the same edge.
    if (state_q == ST_SHOW)  seg_d = lz_blank ? SEG_BLANK : enc_seg;
    else if (waiting)        seg_d = SEG_DASH;
    else                     seg_d = SEG_BLANK;
    dp_d = ~((state_q == ST_SHOW) && (idx_q == 2'd0) && overflow_q);
    an_d = ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      show_q     <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      div_cnt_q  <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= 4'b1111;
    end else begin
      state_q    <= state_d;
      show_q     <= show_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;
  assign busy     = (state_q == ST_CONVERT);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reaction_display.sv
// Directed bench for reaction_display with a scoreboard of expected per-digit display states.
module tb_reaction_display;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        show;
  logic        waiting;
  logic [15:0] value;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  disp_t sb_q[$];

  reaction_display #(.SCAN_DIV(SCAN)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .show     (show),
    .waiting  (waiting),
    .value    (value),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int k);
    case (k)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic push_value(input int v);
    int    sat;
    int    d[4];
    int    first_nz;
    disp_t e;
    sat = (v > 9999) ? 9999 : v;
    first_nz = 0;
    for (int k = 0; k < 4; k++) begin
      d[k] = (sat / (10 ** k)) % 10;
      if (d[k] != 0) first_nz = k;
    end
    for (int k = 0; k < 4; k++) begin
      e.an  = an_of(k);
      e.seg = seg_of(d[k]);
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && k > first_nz) e.seg = 7'h7F;
`endif
      e.dp  = !(k == 0 && v > 9999);
      sb_q.push_back(e);
    end
  endtask

  task automatic push_fill(input logic [6:0] s);
    disp_t e;
    for (int k = 0; k < 4; k++) begin
      e.an  = an_of(k);
      e.seg = s;
      e.dp  = 1'b1;
      sb_q.push_back(e);
    end
  endtask

  task automatic check_scan(input string tag);
    disp_t e;
    int    guard;
    guard = 0;
    while (an !== 4'b1110 && guard < 4 * SCAN + 8) begin
      tick(1);
      guard++;
    end
    chk({tag, "_sync"}, {12'd0, an}, 16'h000E);
    for (int k = 0; k < 4; k++) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 16'd0, 16'd1);
        return;
      end
      e = sb_q.pop_front();
      chk({tag, "_an"},  {12'd0, an},  {12'd0, e.an});
      chk({tag, "_seg"}, {9'd0, seg},  {9'd0, e.seg});
      chk({tag, "_dp"},  {15'd0, dp},  {15'd0, e.dp});
      tick(SCAN);
    end
  endtask

  task automatic capture(input int v, input string tag);
    int n;
    show = 1'b0;
    tick(1);
    value = v[15:0];
    show  = 1'b1;
    push_value(v);
    tick(1);
    value = 16'hFFFF;
    n = 0;
    for (int g = 0; g < 40; g++) begin
      if (busy) n++;
      else if (n > 0) break;
      tick(1);
    end
    chk({tag, "_busy_len"}, n[15:0], 16'd16);
    chk({tag, "_pre_seg"}, {9'd0, seg}, 16'h007F);
    chk({tag, "_ovf"}, {15'd0, overflow}, {15'd0, (v > 9999)});
    tick(1);
    check_scan(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    show    = 1'b0;
    waiting = 1'b0;
    value   = 16'd0;
    tick(3);
    chk("rst_seg",  {9'd0, seg},       16'h007F);
    chk("rst_an",   {12'd0, an},       16'h000F);
    chk("rst_dp",   {15'd0, dp},       16'h0001);
    chk("rst_busy", {15'd0, busy},     16'h0000);
    chk("rst_ovf",  {15'd0, overflow}, 16'h0000);

    reset_n = 1'b1;
    tick(1);
    chk("first_an", {12'd0, an}, 16'h000E);

    waiting = 1'b1;
    tick(2);
    push_fill(7'b0111111);
    check_scan("dash");
    waiting = 1'b0;
    tick(2);
    push_fill(7'h7F);
    check_scan("blank");

    capture(1234, "v1234");

    value = 16'd999;
    tick(3);
    push_value(1234);
    check_scan("no_recap");
    capture(999, "v999");

    capture(10000, "v10000");
    capture(7, "v7");

    show = 1'b0;
    tick(1);
    value = 16'd3210;
    show  = 1'b1;
    tick(8);
    chk("mid_busy", {15'd0, busy}, 16'h0001);
    reset_n = 1'b0;
    show    = 1'b0;
    tick(2);
    chk("mrst_busy", {15'd0, busy},     16'h0000);
    chk("mrst_seg",  {9'd0, seg},       16'h007F);
    chk("mrst_an",   {12'd0, an},       16'h000F);
    chk("mrst_ovf",  {15'd0, overflow}, 16'h0000);
    reset_n = 1'b1;
    tick(1);
    chk("mrst_first_an", {12'd0, an}, 16'h000E);
    capture(55, "v55");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
